// File: rtl/cordic_iter_ctrl_pkg.sv
// Shared definitions for the iterative CORDIC sequencer: FSM encoding,
// Q0.31 angle tables, shift schedule and angle quantisation helpers.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int COORD_CIRCULAR   = 0;
  localparam int COORD_LINEAR     = 1;
  localparam int COORD_HYPERBOLIC = 2;

  // atan(2^-i) in Q0.31
  localparam logic [31:0] ATAN_Q31 [16] = '{
    32'd1686629713, 32'd995675659, 32'd526087673, 32'd267050317,
    32'd134043374,  32'd67087031,  32'd33551701,  32'd16776875,
    32'd8388565,    32'd4194299,   32'd2097151,   32'd1048576,
    32'd524288,     32'd262144,    32'd131072,    32'd65536
  };

  // 2^-i in Q0.31; entry 0 is exactly 1.0, which needs the full unsigned word
  localparam logic [31:0] LIN_Q31 [16] = '{
    32'h8000_0000, 32'h4000_0000, 32'h2000_0000, 32'h1000_0000,
    32'h0800_0000, 32'h0400_0000, 32'h0200_0000, 32'h0100_0000,
    32'h0080_0000, 32'h0040_0000, 32'h0020_0000, 32'h0010_0000,
    32'h0008_0000, 32'h0004_0000, 32'h0002_0000, 32'h0001_0000
  };

  // atanh(2^-i) in Q0.31; i=0 is undefined and never scheduled
  localparam logic [31:0] ATANH_Q31 [16] = '{
    32'd0,          32'd1179625963, 32'd548494837, 32'd269846813,
    32'd134392901,  32'd67130722,   32'd33557163,  32'd16777557,
    32'd8388651,    32'd4194309,    32'd2097153,   32'd1048576,
    32'd524288,     32'd262144,     32'd131072,    32'd65536
  };

  // Shift index for step k. Hyperbolic starts at 1 and repeats 4 and 13
  // so the rotation sequence converges.
  function automatic logic [3:0] sched_shift(input int coord_sys, input logic [3:0] k);
    logic [3:0] s;
    s = k;
    if (coord_sys == COORD_HYPERBOLIC) begin
      if (k < 4'd4)
        s = k + 4'd1;
      else if (k > 4'd13)
        s = k - 4'd1;
      else
        s = k;
    end
    return s;
  endfunction

  function automatic longint angle_q31(input int coord_sys, input logic [3:0] idx);
    logic [31:0] v;
    case (coord_sys)
      COORD_LINEAR:     v = LIN_Q31[idx];
      COORD_HYPERBOLIC: v = ATANH_Q31[idx];
      default:          v = ATAN_Q31[idx];
    endcase
    return longint'({32'd0, v});
  endfunction

  // Move a Q0.31 value onto the 2^n_frac grid, rounding half up.
  function automatic longint to_nfrac(input longint q31, input int n_frac);
    int s;
    s = 31 + n_frac;
    if (s <= 0)
      return q31 <<< (-s);
    return (q31 + (longint'(1) <<< (s - 1))) >>> s;
  endfunction

endpackage

// File: rtl/cordic_iter_ctrl_if.sv
// Operand and result handshakes between the phase logic and the sequencer.
interface cordic_iter_ctrl_if #(
  parameter int BITWIDTH = 8
);
  logic                       in_valid_i;
  logic                       in_ready_o;
  logic signed [BITWIDTH-1:0] in_x_i;
  logic signed [BITWIDTH-1:0] in_y_i;
  logic signed [BITWIDTH-1:0] in_z_i;
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic signed [BITWIDTH-1:0] out_x_o;
  logic signed [BITWIDTH-1:0] out_y_o;
  logic signed [BITWIDTH-1:0] out_z_o;

  // sequencer side
  modport slave (
    input  in_valid_i, in_x_i, in_y_i, in_z_i, out_ready_i,
    output in_ready_o, out_valid_o, out_x_o, out_y_o, out_z_o
  );

  // producer / consumer side
  modport master (
    output in_valid_i, in_x_i, in_y_i, in_z_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_x_o, out_y_o, out_z_o
  );
endinterface

// File: rtl/cordic_iter_ctrl_angle_rom.sv
// Shift index -> quantised micro-rotation angle. The whole table is an
// elaboration-time constant, so this reduces to a small mux.
module cordic_angle_rom
  import cordic_pkg::*;
#(
  parameter int COORDINATE_SYSTEM = 0,
  parameter int N_FRAC            = -7,
  parameter int BITWIDTH          = 8
) (
  input  logic [3:0]                i_idx,
  output logic signed [BITWIDTH-1:0] o_angle
);

  // Linear entry 0 (1.0) does not fit when N_INT=0; clip to the largest code.
  localparam longint MAX_POS = (longint'(1) <<< (BITWIDTH - 1)) - 1;

  logic signed [BITWIDTH-1:0] w_table [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_table
    localparam longint RAW = to_nfrac(angle_q31(COORDINATE_SYSTEM, 4'(gi)), N_FRAC);
    localparam longint SAT = (RAW > MAX_POS) ? MAX_POS : RAW;
    assign w_table[gi] = SAT[BITWIDTH-1:0];
  end

  assign o_angle = w_table[i_idx];

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC sequencer: time-multiplexes one external CordicSlice over
// ITERATIONS micro-rotations, feeding its registered outputs back each step.
module cordic_iter_ctrl
  import cordic_pkg::*;
#(
  parameter int N_INT             = 0,
  parameter int N_FRAC            = -7,
  parameter int COORDINATE_SYSTEM = 0,
  parameter int ITERATIONS        = 7,
  parameter int SHIFT_BITWIDTH    = 4,
  localparam int BITWIDTH         = N_INT - N_FRAC + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  cordic_iter_ctrl_if.slave          io,
  output logic                       busy_o,
  output logic signed [BITWIDTH-1:0] slice_x_o,
  output logic signed [BITWIDTH-1:0] slice_y_o,
  output logic signed [BITWIDTH-1:0] slice_z_o,
  output logic [SHIFT_BITWIDTH-1:0]  slice_shift_o,
  output logic signed [BITWIDTH-1:0] slice_angle_o,
  input  logic signed [BITWIDTH-1:0] slice_x_i,
  input  logic signed [BITWIDTH-1:0] slice_y_i,
  input  logic signed [BITWIDTH-1:0] slice_z_i
);

  localparam logic [3:0] K_LAST = 4'(ITERATIONS - 1);

  state_t                     r_state;
  state_t                     w_state_next;
  logic [3:0]                 r_k;
  logic signed [BITWIDTH-1:0] r_op_x, r_op_y, r_op_z;
  logic signed [BITWIDTH-1:0] r_out_x, r_out_y, r_out_z;
  logic                       w_accept;
  logic [3:0]                 w_sched;
  logic signed [BITWIDTH-1:0] w_angle;

  assign w_sched = sched_shift(COORDINATE_SYSTEM, r_k);

  cordic_angle_rom #(
    .COORDINATE_SYSTEM(COORDINATE_SYSTEM),
    .N_FRAC           (N_FRAC),
    .BITWIDTH         (BITWIDTH)
  ) u_angle_rom (
    .i_idx  (w_sched),
    .o_angle(w_angle)
  );

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // next state plus handshake/status outputs, all decoded from the state
  always_comb begin
    w_state_next   = r_state;
    w_accept       = 1'b0;
    io.in_ready_o  = 1'b0;
    io.out_valid_o = 1'b0;
    busy_o         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        io.in_ready_o = 1'b1;
        if (io.in_valid_i) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy_o = 1'b1;
        if (r_k == K_LAST) w_state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        busy_o       = 1'b1;
        w_state_next = ST_DONE;
      end
      ST_DONE: begin
        io.out_valid_o = 1'b1;
        if (io.out_ready_i) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // step counter: restarts on accept, advances once per RUN cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                r_k <= 4'd0;
    else if (w_accept)        r_k <= 4'd0;
    else if (r_state == ST_RUN) r_k <= r_k + 4'd1;
  end

  // operand registers: start values for step 0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_op_x <= '0;
      r_op_y <= '0;
      r_op_z <= '0;
    end else if (w_accept) begin
      r_op_x <= io.in_x_i;
      r_op_y <= io.in_y_i;
      r_op_z <= io.in_z_i;
    end
  end

  // result registers: the slice output after the final step, held until the next capture
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_x <= '0;
      r_out_y <= '0;
      r_out_z <= '0;
    end else if (r_state == ST_CAPTURE) begin
      r_out_x <= slice_x_i;
      r_out_y <= slice_y_i;
      r_out_z <= slice_z_i;
    end
  end

  assign io.out_x_o = r_out_x;
  assign io.out_y_o = r_out_y;
  assign io.out_z_o = r_out_z;

  // slice drive: operands on step 0, feedback afterwards; idle schedule outside RUN
  always_comb begin
    slice_x_o     = r_op_x;
    slice_y_o     = r_op_y;
    slice_z_o     = r_op_z;
    slice_shift_o = '0;
    slice_angle_o = '0;
    if (r_state == ST_RUN) begin
      if (r_k != 4'd0) begin
        slice_x_o = slice_x_i;
        slice_y_o = slice_y_i;
        slice_z_o = slice_z_i;
      end
      slice_shift_o = SHIFT_BITWIDTH'(w_sched);
      slice_angle_o = w_angle;
    end
  end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Scoreboard bench for cordic_iter_ctrl with a behavioural circular
// rotation-mode slice and a golden model of the complete operation.
`timescale 1ns/1ps
module tb_cordic_iter_ctrl;

  localparam int BW   = 8;
  localparam int ITER = 7;
  localparam int SBW  = 4;
  // quantised atan(2^-k)*128 and atanh(2^-s)*128 for the expected schedules
  localparam int ANG   [ITER] = '{101, 59, 31, 16, 8, 4, 2};
  localparam int HSH   [ITER] = '{1, 2, 3, 4, 4, 5, 6};
  localparam int HANG  [ITER] = '{70, 33, 16, 8, 8, 4, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_iter_ctrl_if #(.BITWIDTH(BW)) u_if ();
  cordic_iter_ctrl_if #(.BITWIDTH(BW)) h_if ();

  logic                 busy, h_busy;
  logic signed [BW-1:0] sx_o, sy_o, sz_o, sang;
  logic signed [BW-1:0] sx_i = '0, sy_i = '0, sz_i = '0;
  logic [SBW-1:0]       ssh;
  logic signed [BW-1:0] hx_o, hy_o, hz_o, hang;
  logic [SBW-1:0]       hsh;
  logic signed [BW-1:0] h_zero = '0;

  cordic_iter_ctrl #(
    .N_INT(0), .N_FRAC(-7), .COORDINATE_SYSTEM(0), .ITERATIONS(ITER), .SHIFT_BITWIDTH(SBW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .io(u_if), .busy_o(busy),
    .slice_x_o(sx_o), .slice_y_o(sy_o), .slice_z_o(sz_o),
    .slice_shift_o(ssh), .slice_angle_o(sang),
    .slice_x_i(sx_i), .slice_y_i(sy_i), .slice_z_i(sz_i)
  );

  cordic_iter_ctrl #(
    .N_INT(0), .N_FRAC(-7), .COORDINATE_SYSTEM(2), .ITERATIONS(ITER), .SHIFT_BITWIDTH(SBW)
  ) dut_h (
    .clk_i(clk), .rst_i(rst), .io(h_if), .busy_o(h_busy),
    .slice_x_o(hx_o), .slice_y_o(hy_o), .slice_z_o(hz_o),
    .slice_shift_o(hsh), .slice_angle_o(hang),
    .slice_x_i(h_zero), .slice_y_i(h_zero), .slice_z_i(h_zero)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;
  logic [3*BW-1:0] exp_q[$];

  function automatic int sat(input int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  // one rotation-mode micro-rotation, saturating to the word
  function automatic logic [3*BW-1:0] rot3(input int x, input int y, input int z,
                                           input int sh, input int ang);
    int s, xn, yn, zn;
    s = (sh > BW - 1) ? BW - 1 : sh;
    if (z >= 0) begin
      xn = x - (y >>> s); yn = y + (x >>> s); zn = z - ang;
    end else begin
      xn = x + (y >>> s); yn = y - (x >>> s); zn = z + ang;
    end
    return {BW'(sat(xn)), BW'(sat(yn)), BW'(sat(zn))};
  endfunction

  // whole operation: ITER rotations with shift k and angle ANG[k]
  function automatic logic [3*BW-1:0] golden(input int x, input int y, input int z);
    logic [3*BW-1:0] v;
    int cx, cy, cz;
    cx = x; cy = y; cz = z;
    v = '0;
    for (int k = 0; k < ITER; k++) begin
      v  = rot3(cx, cy, cz, k, ANG[k]);
      cx = int'($signed(v[3*BW-1 -: BW]));
      cy = int'($signed(v[2*BW-1 -: BW]));
      cz = int'($signed(v[BW-1:0]));
    end
    return v;
  endfunction

  // external slice: registered outputs, clocks every cycle
  always @(posedge clk) {sx_i, sy_i, sz_i} <= rot3(sx_o, sy_o, sz_o, ssh, sang);

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: pops one expectation per result transfer
  always @(negedge clk) begin
    logic [3*BW-1:0] e;
    if (!rst && u_if.out_valid_o && u_if.out_ready_i) begin
      n_txn++;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        $display("txn %0d: result (%0d,%0d,%0d) expected (%0d,%0d,%0d)", n_txn,
                 u_if.out_x_o, u_if.out_y_o, u_if.out_z_o,
                 $signed(e[3*BW-1 -: BW]), $signed(e[2*BW-1 -: BW]), $signed(e[BW-1:0]));
        chk("res_x", u_if.out_x_o, int'($signed(e[3*BW-1 -: BW])));
        chk("res_y", u_if.out_y_o, int'($signed(e[2*BW-1 -: BW])));
        chk("res_z", u_if.out_z_o, int'($signed(e[BW-1:0])));
      end
    end
  end

  task automatic wait_in_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (u_if.in_ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic wait_out_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (u_if.out_valid_o) begin ok = 1'b1; break; end
    end
    if (!ok) chk("out_valid_timeout", 0, 1);
  endtask

  // issue one operand set; returns #1 after the accept edge with in_valid low
  task automatic send(input int x, input int y, input int z);
    bit ok;
    u_if.in_x_i = BW'(x); u_if.in_y_i = BW'(y); u_if.in_z_i = BW'(z);
    u_if.in_valid_i = 1'b1;
    wait_in_ready(ok);
    if (ok) exp_q.push_back(golden(x, y, z));
    @(posedge clk); #1;
    u_if.in_valid_i = 1'b0;
  endtask

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(hi - lo));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int last;
    int ax, ay, az;
    logic [3*BW-1:0] hold;

    u_if.in_valid_i = 1'b0; u_if.out_ready_i = 1'b1;
    u_if.in_x_i = '0; u_if.in_y_i = '0; u_if.in_z_i = '0;
    h_if.in_valid_i = 1'b0; h_if.out_ready_i = 1'b1;
    h_if.in_x_i = '0; h_if.in_y_i = '0; h_if.in_z_i = '0;

    // reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_in_ready", u_if.in_ready_o, 1);
    chk("rst_out_valid", u_if.out_valid_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_x", u_if.out_x_o, 0);
    chk("rst_out_y", u_if.out_y_o, 0);
    chk("rst_out_z", u_if.out_z_o, 0);
    chk("rst_shift", ssh, 0);
    chk("rst_angle", sang, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed rotation with schedule/angle trace, hyperbolic instance in lockstep
    u_if.in_x_i = 8'sd78; u_if.in_y_i = 8'sd0; u_if.in_z_i = 8'sd64;
    h_if.in_x_i = 8'sd78; h_if.in_y_i = 8'sd0; h_if.in_z_i = 8'sd64;
    u_if.in_valid_i = 1'b1; h_if.in_valid_i = 1'b1;
    @(negedge clk);
    chk("dir_in_ready", u_if.in_ready_o, 1);
    chk("hyp_in_ready", h_if.in_ready_o, 1);
    exp_q.push_back(golden(78, 0, 64));
    @(posedge clk); #1;
    u_if.in_valid_i = 1'b0; h_if.in_valid_i = 1'b0;
    for (int k = 0; k < ITER; k++) begin
      chk("run_busy", busy, 1);
      chk("run_in_ready", u_if.in_ready_o, 0);
      chk("run_shift", ssh, k);
      chk("run_angle", sang, ANG[k]);
      chk("hyp_shift", hsh, HSH[k]);
      chk("hyp_angle", hang, HANG[k]);
      if (k == 0) begin
        chk("run_x_op", sx_o, 78); chk("run_y_op", sy_o, 0); chk("run_z_op", sz_o, 64);
        chk("hyp_x_op", hx_o, 78); chk("hyp_y_op", hy_o, 0); chk("hyp_z_op", hz_o, 64);
      end else begin
        chk("run_x_fb", sx_o, sx_i); chk("run_y_fb", sy_o, sy_i); chk("run_z_fb", sz_o, sz_i);
        chk("hyp_x_fb", hx_o, 0); chk("hyp_y_fb", hy_o, 0); chk("hyp_z_fb", hz_o, 0);
      end
      @(posedge clk); #1;
    end
    chk("capture_busy", busy, 1);
    chk("capture_out_valid", u_if.out_valid_o, 0);
    chk("capture_shift", ssh, 0);
    @(posedge clk); #1;
    chk("latency_out_valid", u_if.out_valid_o, 1);
    chk("done_busy", busy, 0);
    chk("rot_x_near_112", int'(u_if.out_x_o >= 109 && u_if.out_x_o <= 115), 1);
    chk("rot_y_near_61", int'(u_if.out_y_o >= 58 && u_if.out_y_o <= 64), 1);
    chk("rot_z_small", int'(u_if.out_z_o >= -2 && u_if.out_z_o <= 2), 1);
    @(posedge clk); #1;

    // backpressure: result held while out_ready low, next operand waits
    u_if.out_ready_i = 1'b0;
    send(rnd(-60, 60), rnd(-60, 60), rnd(-100, 100));
    ax = rnd(-60, 60); ay = rnd(-60, 60); az = rnd(-100, 100);
    u_if.in_x_i = BW'(ax); u_if.in_y_i = BW'(ay); u_if.in_z_i = BW'(az);
    u_if.in_valid_i = 1'b1;
    wait_out_valid(ok);
    hold = (exp_q.size() > 0) ? exp_q[0] : '0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", u_if.out_valid_o, 1);
      chk("bp_in_ready", u_if.in_ready_o, 0);
      chk("bp_hold_x", u_if.out_x_o, int'($signed(hold[3*BW-1 -: BW])));
      chk("bp_hold_y", u_if.out_y_o, int'($signed(hold[2*BW-1 -: BW])));
      chk("bp_hold_z", u_if.out_z_o, int'($signed(hold[BW-1:0])));
      @(negedge clk);
    end
    @(posedge clk); #1;
    u_if.out_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("release_idle", u_if.in_ready_o, 1);
    chk("release_out_valid", u_if.out_valid_o, 0);
    send(ax, ay, az);
    wait_out_valid(ok);
    @(posedge clk); #1;

    // reset in the middle of RUN abandons the operation
    send(rnd(-60, 60), rnd(-60, 60), rnd(-100, 100));
    repeat (3) @(posedge clk); #1;
    chk("mid_run_step3", ssh, 3);
    rst = 1'b1;
    #1;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    chk("mid_rst_in_ready", u_if.in_ready_o, 1);
    chk("mid_rst_out_valid", u_if.out_valid_o, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_x", u_if.out_x_o, 0);
    chk("mid_rst_out_y", u_if.out_y_o, 0);
    chk("mid_rst_out_z", u_if.out_z_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(rnd(-60, 60), rnd(-60, 60), rnd(-100, 100));
    wait_out_valid(ok);
    @(posedge clk); #1;

    // back-to-back: accepts every ITER+3 cycles
    u_if.out_ready_i = 1'b1;
    u_if.in_valid_i  = 1'b1;
    last = -1;
    for (int i = 0; i < 6; i++) begin
      ax = rnd(-60, 60); ay = rnd(-60, 60); az = rnd(-100, 100);
      u_if.in_x_i = BW'(ax); u_if.in_y_i = BW'(ay); u_if.in_z_i = BW'(az);
      wait_in_ready(ok);
      if (ok) begin
        exp_q.push_back(golden(ax, ay, az));
        if (last >= 0) chk("b2b_period", cyc - last, ITER + 3);
        last = cyc;
      end
      @(posedge clk); #1;
    end
    u_if.in_valid_i = 1'b0;

    // drain
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cordic_iter_ctrl.md
Name: cordic_iter_ctrl

Overview:
Iterative sequencer that time-multiplexes a single CordicSlice instance across ITERATIONS micro-rotations. It accepts one (X,Y,Z) operand set through a valid/ready handshake and drives the slice's operand, shift and angle inputs every cycle. It feeds the slice's registered outputs back and captures the final result behind a valid/ready output handshake. It sits between the function-generator phase logic and the CORDIC datapath, replacing an unrolled slice pipeline when area matters more than throughput.

Parameters:
N_INT, 0, integer bits of the fixed-point word (the slice's N_INT); BITWIDTH = N_INT-N_FRAC+1
N_FRAC, -7, LSB exponent (the slice's N_FRAC)
COORDINATE_SYSTEM, 0, 0 circular, 1 linear, 2 hyperbolic; selects angle table and shift schedule
ITERATIONS, 7, micro-rotation steps per operation, including hyperbolic repeats; 1..16
SHIFT_BITWIDTH, 4, width of the slice shift input

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
in_valid_i  in  1  operand valid
in_ready_o  out  1  controller can accept an operand
in_x_i, in_y_i, in_z_i  in  BITWIDTH each  signed start operands
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
out_x_o, out_y_o, out_z_o  out  BITWIDTH each  signed result
busy_o  out  1  high in RUN or CAPTURE
slice_x_o, slice_y_o, slice_z_o  out  BITWIDTH each  operands to the slice X_i/Y_i/Z_i
slice_shift_o  out  SHIFT_BITWIDTH  to the slice shift_value_i
slice_angle_o  out  BITWIDTH  to the slice current_rotation_angle_i
slice_x_i, slice_y_i, slice_z_i  in  BITWIDTH each  from the slice X_o/Y_o/Z_o

Behaviour:
- States: IDLE, RUN, CAPTURE, DONE. Reset (async, rst_i=1): state IDLE, step counter k=0, operand registers 0, out_x/y/z_o=0, out_valid_o=0, busy_o=0. Reset mid-operation abandons the operation; no result is emitted.
- in_ready_o = (state==IDLE). Handshake fires on in_valid_i & in_ready_o.
- IDLE: on handshake, latch in_x/y/z into operand registers, k<=0, go to RUN.
- RUN, step k:
  - slice_x/y/z_o = operand registers when k==0, otherwise slice_x/y/z_i (feedback).
  - slice_shift_o = SCHED[k]; slice_angle_o = ANGLE[SCHED[k]].
  - At each edge k<=k+1. After the edge that completes k==ITERATIONS-1, go to CAPTURE.
- CAPTURE: out_x/y/z_o <= slice_x/y/z_i; go to DONE with out_valid_o=1.
- DONE: outputs held stable while out_ready_i=0. On out_valid_o & out_ready_i, clear out_valid_o and go to IDLE. Result registers keep their value until the next CAPTURE.
- Latency: the first out_valid_o edge is ITERATIONS+1 edges after the accept edge (8 for defaults). Minimum period between accepts is ITERATIONS+3 cycles.
- Slice inputs outside RUN: slice_x/y/z_o = operand registers, slice_shift_o=0, slice_angle_o=0. The slice keeps clocking there, but its outputs are ignored.
- Shift schedule SCHED:
  - circular and linear: 0,1,2,…
  - hyperbolic: 1,2,3,4,4,5,…,13,13,14,… (index 4 and 13 repeated)
  - Values above BITWIDTH-1 are passed unmodified; the slice clamps them.
- ANGLE table: 16 entries per coordinate system, held in Q0.31, converted at elaboration to the N_FRAC grid by arithmetic shift right (31+N_FRAC) with round-half-up.
  - circular: atan(2^-i)
  - linear: 2^-i
  - hyperbolic: atanh(2^-i), i≥1
- Direction decisions and saturation belong to the slice; the controller performs no arithmetic except the counter.

Decomposition:
- Package cordic_pkg: state encoding constants, the three 16-entry Q0.31 angle tables, a schedule function sched_shift(coord_sys, k), and an angle conversion function to_nfrac(q31, N_FRAC).
- One natural sub-module: cordic_angle_rom (combinational lookup of shift index to quantised angle). Instantiated once, here.
- The CordicSlice instance is placed by the parent, not inside this block.

Test Plan:
- Circular rotation, defaults: X=78, Y=0, Z=64 (0.5 rad) -> after 8 cycles out_x≈112, out_y≈61 (±3 LSB), |out_z|≤2.
- Schedule and angle check, defaults: during RUN, slice_shift_o = 0,1,2,3,4,5,6 and slice_angle_o = 101,59,31,16,8,4,2 on consecutive cycles.
- Hyperbolic schedule, COORDINATE_SYSTEM=2, ITERATIONS=7 -> slice_shift_o = 1,2,3,4,4,5,6.
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE while in_valid_i=1 -> outputs stable, in_ready_o=0, no accept. Raise out_ready_i -> IDLE on the next edge, then accept.
- Reset mid-run: assert rst_i at step k=3 -> immediately state IDLE, out_valid_o=0, outputs 0. After deassert, a new operation completes correctly.
- Back-to-back: out_ready_i tied 1, in_valid_i tied 1 -> accepts exactly every 10 cycles (ITERATIONS+3). Each result matches the golden model.
